// File: rtl/simd_upstream_packetizer.sv
// simd_upstream_packetizer: snapshots the SIMD lane-result registers once every
// lane is valid and streams them upstream as a header beat plus data beats,
// then pulses regs_complete so the wrapper can clear its lane valids.
// Optional feature macro: SIMD_UPSTREAM_PACKETIZER_TIMEOUT_EN (partial flush of
// a packet after TIMEOUT_CYCLES of some-but-not-all lanes valid).

// Per-lane snapshot register; lanes not flagged valid are captured as zero.
module simd_upstream_packetizer_lane #(
    parameter int LANE_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  lane_vld,
    input  logic [LANE_WIDTH-1:0] lane_in,
    output logic [LANE_WIDTH-1:0] lane_out
);
    logic [LANE_WIDTH-1:0] snap_q, snap_d;

    // Next snapshot value: capture on load, otherwise hold.
    always_comb begin
        snap_d = snap_q;
        if (load) snap_d = lane_vld ? lane_in : '0;
    end

    // Snapshot register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) snap_q <= '0;
        else        snap_q <= snap_d;
    end

    assign lane_out = snap_q;
endmodule

module simd_upstream_packetizer #(
    parameter int NUM_LANES      = 32,
    parameter int LANE_WIDTH     = 32,
    parameter int LANES_PER_BEAT = 2,
    parameter int PE_ID_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                 clk,
    input  logic                                 reset_poweron,
    input  logic [PE_ID_WIDTH-1:0]               peId,
    input  logic [NUM_LANES*LANE_WIDTH-1:0]      simd__sui__regs,
    input  logic [NUM_LANES-1:0]                 simd__sui__regs_valid,
    output logic                                 sui__simd__regs_complete,
    output logic                                 sui__stu__valid,
    output logic [LANE_WIDTH*LANES_PER_BEAT-1:0] sui__stu__data,
    output logic                                 sui__stu__sop,
    output logic                                 sui__stu__eop,
    input  logic                                 stu__sui__ready
);
    localparam int BEAT_W    = LANE_WIDTH * LANES_PER_BEAT;
    localparam int NUM_BEATS = NUM_LANES / LANES_PER_BEAT;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic [1:0]             drain_q, drain_d;
    logic [NUM_LANES-1:0]   mask_q, mask_d;
    logic [PE_ID_WIDTH-1:0] pe_q, pe_d;
    logic                   load;
    logic                   all_vld;
    logic                   tmo_hit;
    logic [BEAT_W-1:0]      hdr;

    logic [NUM_LANES-1:0][LANE_WIDTH-1:0] snap_lanes;
    logic [NUM_BEATS-1:0][BEAT_W-1:0]     snap_beats;

    assign all_vld    = &simd__sui__regs_valid;
    assign snap_beats = snap_lanes;

    // Snapshot buffer: one register per lane, all loaded on the same edge.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        simd_upstream_packetizer_lane #(.LANE_WIDTH(LANE_WIDTH)) u_lane (
            .clk      (clk),
            .rst_n    (reset_poweron),
            .load     (load),
            .lane_vld (simd__sui__regs_valid[i]),
            .lane_in  (simd__sui__regs[i*LANE_WIDTH +: LANE_WIDTH]),
            .lane_out (snap_lanes[i])
        );
    end

`ifdef SIMD_UPSTREAM_PACKETIZER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Saturating partial-fill timer; only counts in IDLE with some lanes valid.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q != IDLE || load || simd__sui__regs_valid == '0) tmo_d = '0;
        else if (!all_vld && tmo_q != TMO_MAX)                        tmo_d = tmo_q + 1'b1;
    end

    // Timer register.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) tmo_q <= '0;
        else                tmo_q <= tmo_d;
    end

    assign tmo_hit = (tmo_q == TMO_MAX) && (|simd__sui__regs_valid);
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    // Header beat: peId in the LSBs, lane mask above it, zero elsewhere.
    always_comb begin
        hdr                             = '0;
        hdr[PE_ID_WIDTH-1:0]            = pe_q;
        hdr[PE_ID_WIDTH +: NUM_LANES]   = mask_q;
    end

    // Next-state and beat outputs; outputs depend on state only, never on ready.
    always_comb begin
        state_d                  = state_q;
        beat_d                   = beat_q;
        drain_d                  = drain_q;
        load                     = 1'b0;
        sui__stu__valid          = 1'b0;
        sui__stu__sop            = 1'b0;
        sui__stu__eop            = 1'b0;
        sui__stu__data           = '0;
        sui__simd__regs_complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (all_vld || tmo_hit) begin
                    load    = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                sui__stu__valid = 1'b1;
                sui__stu__sop   = 1'b1;
                sui__stu__data  = hdr;
                if (stu__sui__ready) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                sui__stu__valid = 1'b1;
                sui__stu__data  = snap_beats[beat_q];
                sui__stu__eop   = (beat_q == LAST_BEAT);
                if (stu__sui__ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                sui__simd__regs_complete = 1'b1;
                state_d                  = DRAIN;
                drain_d                  = '0;
            end
            DRAIN: begin
                // Three dead cycles let the wrapper's registered clear land.
                if (drain_q == 2'd2) begin
                    state_d = IDLE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Header fields are captured together with the lane snapshot.
    always_comb begin
        mask_d = mask_q;
        pe_d   = pe_q;
        if (load) begin
            mask_d = simd__sui__regs_valid;
            pe_d   = peId;
        end
    end

    // State, counters and header registers.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q <= IDLE;
            beat_q  <= '0;
            drain_q <= '0;
            mask_q  <= '0;
            pe_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            mask_q  <= mask_d;
            pe_q    <= pe_d;
        end
    end
endmodule
